// File: rtl/rx_word_fifo.sv
// rtl/rx_word_fifo.sv - byte-to-word assembler feeding a DEPTH-entry word FIFO with valid/ready output
// Optional idle timeout on partial words: define RX_WORD_TIMEOUT_EN.
module rx_word_fifo #(
  parameter int DATA_W      = 128,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic [7:0]               rx_byte,
  input  logic                     rx_byte_valid,
  input  logic                     clear,
  output logic [DATA_W-1:0]        word_data,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     partial,
`ifdef RX_WORD_TIMEOUT_EN
  output logic                     timeout_pulse,
`endif
  output logic                     overrun
);

  localparam int NB    = DATA_W / 8;
  localparam int CW    = $clog2(NB);
  localparam int PW    = $clog2(DEPTH);
  localparam int CNT_W = PW + 1;

  if ((DATA_W % 8) != 0 || DATA_W < 16 || DEPTH < 2 ||
      (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("rx_word_fifo: illegal parameter set");
  end

  typedef enum logic {IDLE, ASSEMBLE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       byte_cnt;
  logic [DATA_W-1:0]   asm_q;
  logic [DATA_W-1:0]   word_in;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic                take_byte, last_byte, push, pop, tmo;

  assign take_byte  = rx_byte_valid && !clear;
  assign last_byte  = take_byte && (byte_cnt == CW'(NB - 1));
  // The final byte is still on the input, so splice it in rather than waiting a cycle.
  assign word_in    = {asm_q[DATA_W-1:8], rx_byte};
  assign pop        = word_valid && word_ready && !clear;
  assign push       = last_byte && (!full || pop);

  assign word_valid = (count != '0);
  assign full       = (count == CNT_W'(DEPTH));
  assign partial    = (state_q == ASSEMBLE);
  assign word_data  = mem[rd_ptr];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (take_byte) state_d = ASSEMBLE;
      ASSEMBLE: if (clear || tmo || last_byte) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      byte_cnt <= '0;
      asm_q    <= '0;
    end else begin
      state_q <= state_d;
      if (clear || tmo) begin
        byte_cnt <= '0;
      end else if (take_byte) begin
        byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
        // MSB-first: byte k occupies bits [DATA_W-1-8k -: 8].
        for (int k = 0; k < NB; k++) begin
          if (byte_cnt == CW'(k)) asm_q[DATA_W-1-8*k -: 8] <= rx_byte;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= word_in;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (last_byte && !push) overrun <= 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef RX_WORD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] idle_cnt;

  // Fires on the TIMEOUT_CYC-th consecutive idle cycle inside a word.
  assign tmo = (state_q == ASSEMBLE) && !rx_byte_valid && !clear &&
               (idle_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      idle_cnt      <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= tmo;
      if (clear || tmo || rx_byte_valid || state_q != ASSEMBLE) idle_cnt <= '0;
      else idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

endmodule

// File: tb/tb_rx_word_fifo.sv
// tb/tb_rx_word_fifo.sv - directed self-checking bench for rx_word_fifo
module tb_rx_word_fifo;

  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          rx_byte_valid = 1'b0;
  logic          clear = 1'b0;
  logic [DW-1:0] word_data;
  logic          word_valid;
  logic          word_ready = 1'b0;
  logic [2:0]    count;
  logic          full;
  logic          partial;
  logic          overrun;
`ifdef RX_WORD_TIMEOUT_EN
  logic          timeout_pulse;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  rx_word_fifo #(.DATA_W(DW), .DEPTH(4), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .n_rst(n_rst), .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
    .clear(clear), .word_data(word_data), .word_valid(word_valid),
    .word_ready(word_ready), .count(count), .full(full), .partial(partial),
`ifdef RX_WORD_TIMEOUT_EN
    .timeout_pulse(timeout_pulse),
`endif
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte       = b;
    rx_byte_valid = 1'b1;
    tick();
    rx_byte_valid = 1'b0;
  endtask

  task automatic send_word_const(input logic [7:0] b);
    for (int i = 0; i < 16; i++) send_byte(b);
  endtask

  function automatic logic [DW-1:0] rep_word(input logic [7:0] b);
    return {16{b}};
  endfunction

  task automatic do_reset();
    n_rst = 1'b0;
    clear = 1'b0;
    word_ready = 1'b0;
    rx_byte_valid = 1'b0;
    tick();
    tick();
    n_rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", word_valid); end
    n_checks++; if (partial !== 1'b0) begin n_fail++; $display("FAIL reset_partial: got %b want 0", partial); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    n_checks++; if (word_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", word_data); end
  endtask

  task automatic test_single_word();
    send_byte(8'h00);
    n_checks++; if (partial !== 1'b1) begin n_fail++; $display("FAIL first_byte_partial: got %b want 1", partial); end
    for (int i = 1; i < 15; i++) send_byte(8'(i));
    n_checks++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL early_valid: got %b want 0", word_valid); end
    send_byte(8'h0F);
    n_checks++; if (word_valid !== 1'b1) begin n_fail++; $display("FAIL word_valid_latency: got %b want 1", word_valid); end
    n_checks++; if (word_data !== 128'h000102030405060708090A0B0C0D0E0F) begin n_fail++; $display("FAIL word_order: got %h want 000102030405060708090a0b0c0d0e0f", word_data); end
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", count); end
    n_checks++; if (partial !== 1'b0) begin n_fail++; $display("FAIL single_partial: got %b want 0", partial); end
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    n_checks++; if (count !== 3'd0 || word_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop: got count=%0d valid=%b want 0/0", count, word_valid); end
  endtask

  task automatic test_empty_ready();
    word_ready = 1'b1;
    tick();
    tick();
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL empty_pop_count: got %0d want 0", count); end
    send_word_const(8'h55);
    n_checks++; if (count !== 3'd1 || word_valid !== 1'b1) begin n_fail++; $display("FAIL push_empty_with_ready: got count=%0d valid=%b want 1/1", count, word_valid); end
    n_checks++; if (word_data !== rep_word(8'h55)) begin n_fail++; $display("FAIL push_empty_data: got %h want 5555..55", word_data); end
    tick();
    word_ready = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL drain_after_empty: got %0d want 0", count); end
  endtask

  task automatic test_overrun();
    for (int n = 0; n < 4; n++) send_word_const(8'(8'h10 + n));
    n_checks++; if (full !== 1'b1 || count !== 3'd4) begin n_fail++; $display("FAIL fill_full: got full=%b count=%0d want 1/4", full, count); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL no_early_overrun: got %b want 0", overrun); end
    send_word_const(8'h14);
    n_checks++; if (overrun !== 1'b1 || count !== 3'd4) begin n_fail++; $display("FAIL overrun_set: got ovr=%b count=%0d want 1/4", overrun, count); end
    n_checks++; if (partial !== 1'b0) begin n_fail++; $display("FAIL overrun_idle: got partial=%b want 0", partial); end
    for (int n = 0; n < 4; n++) begin
      n_checks++; if (word_data !== rep_word(8'(8'h10 + n))) begin n_fail++; $display("FAIL pop_order_%0d: got %h want %h", n, word_data, rep_word(8'(8'h10 + n))); end
      word_ready = 1'b1;
      tick();
      word_ready = 1'b0;
    end
    n_checks++; if (count !== 3'd0 || word_valid !== 1'b0) begin n_fail++; $display("FAIL drained: got count=%0d valid=%b want 0/0", count, word_valid); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: got %b want 0", overrun); end
  endtask

  task automatic test_push_pop_full();
    for (int n = 0; n < 4; n++) send_word_const(8'(8'h20 + n));
    for (int i = 0; i < 15; i++) send_byte(8'h24);
    word_ready = 1'b1;
    send_byte(8'h24);
    word_ready = 1'b0;
    n_checks++; if (overrun !== 1'b0 || count !== 3'd4) begin n_fail++; $display("FAIL push_pop_full: got ovr=%b count=%0d want 0/4", overrun, count); end
    n_checks++; if (word_data !== rep_word(8'h21)) begin n_fail++; $display("FAIL push_pop_head: got %h want 2121..21", word_data); end
    word_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    word_ready = 1'b0;
    n_checks++; if (word_data !== rep_word(8'h24) || count !== 3'd1) begin n_fail++; $display("FAIL push_pop_tail: got %h count=%0d want 2424..24/1", word_data, count); end
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
  endtask

  task automatic test_clear();
    send_word_const(8'h77);
    for (int i = 0; i < 7; i++) send_byte(8'(8'h30 + i));
    clear = 1'b1;
    send_byte(8'h37);
    clear = 1'b0;
    n_checks++; if (partial !== 1'b0 || count !== 3'd0 || word_valid !== 1'b0) begin n_fail++; $display("FAIL clear_state: got partial=%b count=%0d valid=%b want 0/0/0", partial, count, word_valid); end
    for (int i = 0; i < 16; i++) send_byte(8'(8'hA0 + i));
    n_checks++; if (word_data !== 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF || count !== 3'd1) begin n_fail++; $display("FAIL after_clear_word: got %h count=%0d want a0a1..af/1", word_data, count); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) send_byte(8'hC0);
    #2;
    n_rst = 1'b0;
    #1;
    n_checks++; if (partial !== 1'b0) begin n_fail++; $display("FAIL async_reset_partial: got %b want 0", partial); end
    tick();
    n_rst = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) send_byte(8'(8'h40 + i));
    n_checks++; if (word_data !== 128'h404142434445464748494A4B4C4D4E4F) begin n_fail++; $display("FAIL after_reset_word: got %h want 4041..4f", word_data); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

`ifdef RX_WORD_TIMEOUT_EN
  task automatic test_timeout();
    for (int i = 0; i < 3; i++) send_byte(8'hEE);
    for (int i = 0; i < 15; i++) tick();
    n_checks++; if (timeout_pulse !== 1'b0 || partial !== 1'b1) begin n_fail++; $display("FAIL timeout_early: got pulse=%b partial=%b want 0/1", timeout_pulse, partial); end
    tick();
    n_checks++; if (timeout_pulse !== 1'b1 || partial !== 1'b0) begin n_fail++; $display("FAIL timeout_fire: got pulse=%b partial=%b want 1/0", timeout_pulse, partial); end
    tick();
    n_checks++; if (timeout_pulse !== 1'b0) begin n_fail++; $display("FAIL timeout_one_cycle: got %b want 0", timeout_pulse); end
    for (int i = 0; i < 16; i++) send_byte(8'(8'hB0 + i));
    n_checks++; if (word_data !== 128'hB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF || count !== 3'd1) begin n_fail++; $display("FAIL timeout_clean_word: got %h count=%0d want b0b1..bf/1", word_data, count); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_empty_ready();
    test_overrun();
    test_push_pop_full();
    test_clear();
    test_async_reset();
`ifdef RX_WORD_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
